// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage registers and hazard-unit control encoding.
// PIPE_STAGE_REG_PARITY_EN adds a stored parity bit to every stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        CTL_RESET = 2'd0,
        CTL_FLUSH = 2'd1,
        CTL_STALL = 2'd2,
        CTL_SHIFT = 2'd3
    } ctl_e;

    // Per-stage metadata; the data field is added by the user module since its width is a parameter.
    typedef struct packed {
        logic valid;
`ifdef PIPE_STAGE_REG_PARITY_EN
        logic par;
`endif
    } stage_meta_t;

    function automatic ctl_e ctl_decode(input logic rst, input logic flush, input logic stall);
        if (rst)   return CTL_RESET;
        if (flush) return CTL_FLUSH;
        if (stall) return CTL_STALL;
        return CTL_SHIFT;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline stage: load-enable register with synchronous clear and async active-high reset.
module pipe_slot #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (en_i) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// WIDTH-bit, DEPTH-stage delay line with valid bits, stall, flush and occupancy count.
// Define PIPE_STAGE_REG_PARITY_EN to store a parity bit per stage and drive parity_err.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           d,
    input  logic                       valid_in,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       par_inject,
    output logic [WIDTH-1:0]           q,
    output logic                       valid_out,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic                       parity_err
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        stage_meta_t      meta;
        logic [WIDTH-1:0] data;
    } stage_t;

    localparam int SW = $bits(stage_t);

    ctl_e   ctl;
    logic   clr;
    logic   en;
    stage_t in_s;
    stage_t st_q [DEPTH];
    stage_t last_s;
    logic [OCC_W-1:0] occ_sum;

    assign ctl = ctl_decode(reset, flush, stall);
    assign clr = (ctl == CTL_FLUSH);
    assign en  = (ctl == CTL_SHIFT);

    // Bubbles always enter with zero data (and zero parity) so idle stages stay clean.
    always_comb begin
        in_s            = '0;
        in_s.meta.valid = valid_in;
        in_s.data       = valid_in ? d : '0;
`ifdef PIPE_STAGE_REG_PARITY_EN
        in_s.meta.par   = valid_in ? (^d ^ par_inject) : 1'b0;
`endif
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        stage_t slot_in;
        if (i == 0) begin : g_head
            assign slot_in = in_s;
        end else begin : g_tail
            assign slot_in = st_q[i-1];
        end

        pipe_slot #(.W(SW)) u_slot (
            .clk    (clk),
            .reset  (reset),
            .clr_i  (clr),
            .en_i   (en),
            .data_i (slot_in),
            .data_o (st_q[i])
        );
    end

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + OCC_W'(st_q[i].meta.valid);
        end
    end

    assign last_s    = st_q[DEPTH-1];
    assign q         = last_s.data;
    assign valid_out = last_s.meta.valid;
    assign occ       = occ_sum;

`ifdef PIPE_STAGE_REG_PARITY_EN
    assign parity_err = last_s.meta.valid & (^last_s.data ^ last_s.meta.par);
`else
    logic par_inject_unused;
    assign par_inject_unused = par_inject;
    assign parity_err        = 1'b0;
`endif

endmodule
